// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers, step kinds and default parameters
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_WRAP  = 1;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } step_op_t;

  // Operates on zero-extended values up to MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/b2g_converter.sv
// rtl/b2g_converter.sv - combinational binary-to-Gray converter
module b2g_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - up/down counter with registered Gray, binary and terminal-count outputs
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WRAP  = DEFAULT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               DO_WRAP  = (WRAP != 0);

  step_op_t         op;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             tc_nxt;

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_UP : OP_DOWN;
    end
  end

  // Ends are found by explicit compare; a blocked saturating step still raises tc.
  always_comb begin
    bin_nxt = binary;
    tc_nxt  = 1'b0;
    unique case (op)
      OP_LOAD: bin_nxt = load_bin;
      OP_UP: begin
        if (binary == MAX_VAL) begin
          tc_nxt  = 1'b1;
          bin_nxt = DO_WRAP ? ZERO_VAL : MAX_VAL;
        end else begin
          bin_nxt = binary + ONE_VAL;
        end
      end
      OP_DOWN: begin
        if (binary == ZERO_VAL) begin
          tc_nxt  = 1'b1;
          bin_nxt = DO_WRAP ? MAX_VAL : ZERO_VAL;
        end else begin
          bin_nxt = binary - ONE_VAL;
        end
      end
      default: bin_nxt = binary;
    endcase
  end

  // Gray is derived from the next binary value so both registers update together.
  b2g_converter #(.WIDTH(WIDTH)) u_b2g (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary <= '0;
      gray   <= '0;
      tc     <= 1'b0;
    end else begin
      binary <= bin_nxt;
      gray   <= gray_nxt;
      tc     <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - directed and randomized checks of gray_code_counter in wrap and saturate modes
module tb_gray_code_counter;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_bin;
  logic [3:0] w_gray, w_bin, s_gray, s_bin;
  logic       w_tc, s_tc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(4), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(w_gray), .binary(w_bin), .tc(w_tc)
  );

  gray_code_counter #(.WIDTH(4), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray(s_gray), .binary(s_bin), .tc(s_tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_w(input string tag, input int b, input int g, input bit t);
    check({tag, " wrap binary"}, 32'(w_bin), 32'(b));
    check({tag, " wrap gray"},   32'(w_gray), 32'(g));
    check({tag, " wrap tc"},     32'(w_tc), 32'(t));
  endtask

  task automatic expect_s(input string tag, input int b, input int g, input bit t);
    check({tag, " sat binary"}, 32'(s_bin), 32'(b));
    check({tag, " sat gray"},   32'(s_gray), 32'(g));
    check({tag, " sat tc"},     32'(s_tc), 32'(t));
  endtask

  function automatic void model(input bit wrap, input bit m_load, input bit m_en, input bit m_up,
                                input int lb, inout int b, output bit t);
    t = 1'b0;
    if (m_load) begin
      b = lb;
    end else if (m_en && m_up) begin
      if (b == 15) begin t = 1'b1; if (wrap) b = 0; end
      else b = b + 1;
    end else if (m_en) begin
      if (b == 0) begin t = 1'b1; if (wrap) b = 15; end
      else b = b - 1;
    end
  endfunction

  initial begin
    int gray_seq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    logic [3:0] prev;
    int  mw, ms;
    bit  tw, ts;

    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'd0;
    tick();
    tick();
    expect_w("reset", 0, 0, 1'b0);
    expect_s("reset", 0, 0, 1'b0);

    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k < 16; k++) begin
      prev = w_gray;
      tick();
      expect_w($sformatf("count%0d", k), k, gray_seq[k], 1'b0);
      check($sformatf("onebit%0d", k), 32'($countones(w_gray ^ prev)), 32'd1);
    end
    expect_s("count15", 15, 4'b1000, 1'b0);

    tick();
    expect_w("wrap up", 0, 0, 1'b1);
    expect_s("sat up blocked", 15, 4'b1000, 1'b1);
    en = 1'b0;
    tick();
    expect_w("idle after wrap", 0, 0, 1'b0);
    expect_s("idle after block", 15, 4'b1000, 1'b0);
    en = 1'b1;
    tick();
    expect_s("sat up blocked again", 15, 4'b1000, 1'b1);
    expect_w("step after wrap", 1, 1, 1'b0);
    tick();
    expect_s("sat up blocked repeat", 15, 4'b1000, 1'b1);
    expect_w("step two", 2, 3, 1'b0);

    load = 1'b1; load_bin = 4'b1011;
    tick();
    expect_w("load wins", 4'b1011, 4'b1110, 1'b0);
    expect_s("load wins", 4'b1011, 4'b1110, 1'b0);
    load = 1'b0;
    tick();
    expect_w("after load", 4'b1100, 4'b1010, 1'b0);

    load = 1'b1; load_bin = 4'b0000;
    tick();
    load = 1'b0; up = 1'b0;
    tick();
    expect_s("sat down 1", 0, 0, 1'b1);
    expect_w("wrap down", 15, 4'b1000, 1'b1);
    tick();
    expect_s("sat down 2", 0, 0, 1'b1);
    expect_w("down 14", 14, 4'b1001, 1'b0);
    tick();
    expect_s("sat down 3", 0, 0, 1'b1);

    load = 1'b1; load_bin = 4'b0100; up = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    expect_w("mid count", 4'b0110, 4'b0101, 1'b0);
    rst_n = 1'b0; load = 1'b1; load_bin = 4'b1111;
    tick();
    expect_w("reset wins", 0, 0, 1'b0);
    expect_s("reset wins", 0, 0, 1'b0);
    rst_n = 1'b1; load = 1'b0;
    tick();
    expect_w("resume", 1, 1, 1'b0);

    mw = 1; ms = 1;
    for (int c = 0; c < 1000; c++) begin
      en       = 1'($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      load     = 1'($urandom_range(0, 15) == 0);
      load_bin = 4'($urandom_range(0, 15));
      model(1'b1, load, en, up, int'(load_bin), mw, tw);
      model(1'b0, load, en, up, int'(load_bin), ms, ts);
      tick();
      check("e2e wrap g2b", gray2bin(32'(w_gray)), 32'(w_bin));
      check("e2e wrap binary", 32'(w_bin), 32'(mw));
      check("e2e wrap gray", 32'(w_gray), 32'(mw ^ (mw >> 1)));
      check("e2e wrap tc", 32'(w_tc), 32'(tw));
      check("e2e sat binary", 32'(s_bin), 32'(ms));
      check("e2e sat gray", 32'(s_gray), 32'(ms ^ (ms >> 1)));
      check("e2e sat tc", 32'(s_tc), 32'(ts));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
